// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write-side arbiter sharing one FIFO among NREQ producers.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (shared with the attached FIFO)
//   req        per-requester write request, held with data until granted
//   req_data   requester i data at [i*DW +: DW]
//   gnt        combinational one-hot grant; transfer on the edge where req[i] & gnt[i]
//   fifo_re    read enable the consumer presents to the FIFO
//   fifo_empty FIFO empty flag
//   fifo_we    registered FIFO write enable
//   fifo_din   registered FIFO write data
//   count      predicted occupancy, including a write still in flight
//   full_pred  registered, high when count == DEPTH
module fifo_wr_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DW-1:0]         req_data,
  output logic [NREQ-1:0]            gnt,
  input  logic                       fifo_re,
  input  logic                       fifo_empty,
  output logic                       fifo_we,
  output logic [DW-1:0]              fifo_din,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full_pred
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [IW-1:0] LastInit = IW'(NREQ - 1);

  logic [IW-1:0] last_q;
  logic [CW-1:0] count_q, count_d;
  logic          we_q;
  logic [DW-1:0] din_q;
  logic          full_q;

  logic          read_ok;
  logic          space;
  logic          xfer;
  logic [IW-1:0] gnt_idx;

  assign read_ok = fifo_re & ~fifo_empty;
  // A read accepted this cycle frees a slot for the write that lands next edge.
  assign space   = (count_q < DepthC) | read_ok;

  // Scan from the requester after the last winner, wrapping around.
  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    idx     = 0;
    if (!rst && space) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        idx = (32'(last_q) + k) % NREQ;
        if (!xfer && req[idx]) begin
          xfer         = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = IW'(idx);
        end
      end
    end
  end

  // Decrement only on a read the FIFO really accepts; the zero guard is defensive.
  always_comb begin
    count_d = count_q;
    case ({xfer, read_ok && (count_q != '0)})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      din_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      last_q  <= LastInit;
    end else begin
      we_q    <= xfer;
      count_q <= count_d;
      full_q  <= (count_d == DepthC);
      if (xfer) begin
        din_q  <= req_data[32'(gnt_idx)*DW +: DW];
        last_q <= gnt_idx;
      end
    end
  end

  assign fifo_we   = we_q;
  assign fifo_din  = din_q;
  assign count     = count_q;
  assign full_pred = full_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: randomized bench for fifo_wr_arb with a queue-based reference
// of the arbiter and the attached FIFO.
module tb_fifo_wr_arb;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic                fifo_re;
  logic                fifo_empty;
  logic                fifo_we;
  logic [DW-1:0]       fifo_din;
  logic [CW-1:0]       count;
  logic                full_pred;

  fifo_wr_arb #(
    .NREQ  (NREQ),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_re    (fifo_re),
    .fifo_empty (fifo_empty),
    .fifo_we    (fifo_we),
    .fifo_din   (fifo_din),
    .count      (count),
    .full_pred  (full_pred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: FIFO contents, one write in flight, round-robin pointer.
  logic [DW-1:0] mfifo[$];
  bit            pend_v = 1'b0;
  logic [DW-1:0] pend_d = '0;
  logic [DW-1:0] exp_din = '0;
  int            m_last = NREQ - 1;
  bit            xfer_v = 1'b0;
  int            xfer_i = 0;
  int            fair_wait[NREQ];
  int            n_gnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int req_pct, input logic [NREQ-1:0] mask, input int re_pct,
                      input int drop_pct, input bit do_rst);
    logic [NREQ-1:0] eg;
    int              gi;
    int              dgi;
    bit              rok;
    bit              keep;
    int              occ;
    @(negedge clk);
    rst = do_rst;
    for (int i = 0; i < NREQ; i++) begin
      // Held requests keep their data until granted (or a random drop).
      keep = req[i] && !(xfer_v && xfer_i == i) && ($urandom_range(0, 99) >= drop_pct);
      if (!keep) begin
        req[i] = mask[i] && ($urandom_range(0, 99) < req_pct);
        req_data[i*DW +: DW] = DW'($urandom);
        fair_wait[i] = 0;
      end
    end
    fifo_re    = ($urandom_range(0, 99) < re_pct);
    fifo_empty = (mfifo.size() == 0);
    #1;
    occ = mfifo.size() + int'(pend_v);
    rok = fifo_re && (mfifo.size() != 0);
    eg  = '0;
    gi  = -1;
    if (!rst && (occ < DEPTH || rok)) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (gi < 0 && req[(m_last + k) % NREQ]) gi = (m_last + k) % NREQ;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    check("gnt", 32'(gnt), 32'(eg));

    // Fairness measured on the DUT's own grant.
    dgi = -1;
    for (int i = 0; i < NREQ; i++) if (gnt[i] && req[i]) dgi = i;
    if (dgi >= 0) begin
      n_gnt++;
      check("fair_wait", 32'(fair_wait[dgi] <= NREQ - 1), 32'd1);
      for (int i = 0; i < NREQ; i++) if (i != dgi && req[i]) fair_wait[i]++;
    end

    @(posedge clk);
    if (rst) begin
      mfifo.delete();
      pend_v  = 1'b0;
      exp_din = '0;
      m_last  = NREQ - 1;
      xfer_v  = 1'b0;
      for (int i = 0; i < NREQ; i++) fair_wait[i] = 0;
    end else begin
      if (rok) void'(mfifo.pop_front());
      if (pend_v) mfifo.push_back(pend_d);
      pend_v = (gi >= 0);
      xfer_v = (gi >= 0);
      if (gi >= 0) begin
        pend_d  = req_data[gi*DW +: DW];
        exp_din = pend_d;
        m_last  = gi;
        xfer_i  = gi;
      end
    end
    #1;
    occ = mfifo.size() + int'(pend_v);
    check("fifo_we", 32'(fifo_we), 32'(pend_v));
    check("fifo_din", 32'(fifo_din), 32'(exp_din));
    check("count", 32'(count), 32'(occ));
    check("full_pred", 32'(full_pred), 32'(occ == DEPTH));
    // A write landing on a full FIFO would be an overflow.
    if (fifo_we) check("no_overflow", 32'(mfifo.size() < DEPTH), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_data   = '0;
    fifo_re    = 1'b0;
    fifo_empty = 1'b1;
    for (int i = 0; i < NREQ; i++) fair_wait[i] = 0;

    step(0, '0, 0, 0, 1'b1);
    step(0, '0, 0, 0, 1'b1);

    // Fill from a single requester with no reads: exactly DEPTH grants.
    n_gnt = 0;
    for (int c = 0; c < 20; c++) step(100, 4'b0001, 0, 0, 1'b0);
    check("fill_grants", 32'(n_gnt), 32'(DEPTH));
    check("fill_full", 32'(full_pred), 32'd1);

    // Full FIFO with a concurrent read: grants still flow, count pinned at DEPTH.
    n_gnt = 0;
    for (int c = 0; c < 4; c++) step(100, 4'b0100, 100, 0, 1'b0);
    check("full_rd_grants", 32'(n_gnt), 32'd4);
    check("full_rd_count", 32'(count), 32'(DEPTH));

    // All requesters with continuous draining.
    for (int c = 0; c < 12; c++) step(100, 4'b1111, 100, 0, 1'b0);
    for (int c = 0; c < 24; c++) step(0, '0, 100, 0, 1'b0);
    check("drained", 32'(count), 32'd0);

    // Read one cycle after the grant sees an empty FIFO; the next one decrements.
    step(0, '0, 0, 0, 1'b1);
    step(100, 4'b0001, 0, 0, 1'b0);
    step(0, '0, 100, 0, 1'b0);
    check("lat_hold", 32'(count), 32'd1);
    step(0, '0, 100, 0, 1'b0);
    check("lat_dec", 32'(count), 32'd0);

    // Requesters 0 and 3 hammering from the reset pointer.
    step(0, '0, 0, 0, 1'b1);
    for (int c = 0; c < 10; c++) step(100, 4'b1001, 100, 0, 1'b0);

    // Reset in the middle of a burst.
    step(0, '0, 0, 0, 1'b1);
    for (int c = 0; c < 9; c++) step(100, 4'b1111, 0, 0, 1'b0);
    check("burst_count", 32'(count), 32'd9);
    check("burst_we", 32'(fifo_we), 32'd1);
    step(100, 4'b1111, 0, 0, 1'b1);
    check("rst_we", 32'(fifo_we), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    step(100, 4'b1110, 0, 0, 1'b0);

    // Random mix of request density, read rate, drops and occasional reset.
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 100), NREQ'($urandom), $urandom_range(0, 100), 5,
           ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
